// File: rtl/usb_protocol_fsm_if.sv
// Signal bundle between the USB transaction engine, the read/write controller
// above it and the encoder/decoder datapath below it.
interface usb_protocol_fsm_if;
    logic        txn_start;
    logic        txn_is_in;
    logic [6:0]  txn_addr;
    logic [3:0]  txn_endp;
    logic [63:0] txn_wdata;
    logic        txn_done;
    logic        txn_success;
    logic [63:0] txn_rdata;
    logic [98:0] pkt_in;
    logic        pkt_in_avail;
    logic        encoder_ready;
    logic [98:0] pkt_out;
    logic        pkt_out_avail;
    logic        data_good;
    logic        decoder_ready;
    logic        re;

    // master: the transaction engine itself
    modport master (
        input  txn_start, txn_is_in, txn_addr, txn_endp, txn_wdata,
        output txn_done, txn_success, txn_rdata,
        output pkt_in, pkt_in_avail,
        input  encoder_ready,
        input  pkt_out, pkt_out_avail, data_good, decoder_ready,
        output re
    );

    // slave: controller plus datapath surrounding the engine
    modport slave (
        output txn_start, txn_is_in, txn_addr, txn_endp, txn_wdata,
        input  txn_done, txn_success, txn_rdata,
        input  pkt_in, pkt_in_avail,
        output encoder_ready,
        output pkt_out, pkt_out_avail, data_good, decoder_ready,
        input  re
    );
endinterface

// File: rtl/usb_protocol_fsm.sv
// Host-side USB transaction engine: runs OUT/IN transactions (token, data,
// handshake) with receive timeout and bounded retry.
module usb_protocol_fsm #(
    parameter int         TIMEOUT   = 255,
    parameter int         MAX_RETRY = 8,
    parameter logic [7:0] PID_OUT   = 8'hE1,
    parameter logic [7:0] PID_IN    = 8'h69,
    parameter logic [7:0] PID_DATA0 = 8'hC3,
    parameter logic [7:0] PID_ACK   = 8'hD2,
    parameter logic [7:0] PID_NAK   = 8'h5A
) (
    input  logic                clk,
    input  logic                rst_b,
    usb_protocol_fsm_if.master  bus
);

    // Each *_WAIT state is encoded as its *_SEND state plus one.
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_TOK_SEND = 4'd1;
    localparam logic [3:0] S_TOK_WAIT = 4'd2;
    localparam logic [3:0] S_DAT_SEND = 4'd3;
    localparam logic [3:0] S_DAT_WAIT = 4'd4;
    localparam logic [3:0] S_ACK_SEND = 4'd5;
    localparam logic [3:0] S_ACK_WAIT = 4'd6;
    localparam logic [3:0] S_NAK_SEND = 4'd7;
    localparam logic [3:0] S_NAK_WAIT = 4'd8;
    localparam logic [3:0] S_RX_WAIT  = 4'd9;
    localparam logic [3:0] S_RETRY    = 4'd10;
    localparam logic [3:0] S_DONE     = 4'd11;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

    logic [3:0]  state_reg;
    logic        is_in_reg;
    logic [6:0]  addr_reg;
    logic [3:0]  endp_reg;
    logic [63:0] wdata_reg;
    logic [3:0]  retry_reg;
    logic [7:0]  timer_reg;
    logic        seen_low_reg;
    logic [98:0] pkt_in_reg;
    logic        pkt_in_avail_reg;
    logic        txn_done_reg;
    logic        txn_success_reg;
    logic [63:0] txn_rdata_reg;
    logic        re_reg;

    logic [98:0] send_pkt;
    logic        send_done;
    logic [7:0]  timer_inc;
    logic [3:0]  retry_inc;
    logic [7:0]  rx_pid;
    logic        is_send_state;

    assign send_done     = seen_low_reg && bus.encoder_ready;
    assign timer_inc     = (timer_reg == TIMEOUT_CNT) ? timer_reg : timer_reg + 8'd1;
    assign retry_inc     = retry_reg + 4'd1;
    assign rx_pid        = bus.pkt_out[98:91];
    assign is_send_state = (state_reg == S_TOK_SEND) || (state_reg == S_DAT_SEND) ||
                           (state_reg == S_ACK_SEND) || (state_reg == S_NAK_SEND);

    always_comb begin
        send_pkt = '0;
        case (state_reg)
            S_TOK_SEND: send_pkt = {(is_in_reg ? PID_IN : PID_OUT), addr_reg, endp_reg, 80'd0};
            S_DAT_SEND: send_pkt = {PID_DATA0, wdata_reg, 27'd0};
            S_ACK_SEND: send_pkt = {PID_ACK, 91'd0};
            S_NAK_SEND: send_pkt = {PID_NAK, 91'd0};
            default:    send_pkt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg        <= S_IDLE;
            is_in_reg        <= 1'b0;
            addr_reg         <= '0;
            endp_reg         <= '0;
            wdata_reg        <= '0;
            retry_reg        <= '0;
            timer_reg        <= '0;
            seen_low_reg     <= 1'b0;
            pkt_in_reg       <= '0;
            pkt_in_avail_reg <= 1'b0;
            txn_done_reg     <= 1'b0;
            txn_success_reg  <= 1'b0;
            txn_rdata_reg    <= '0;
            re_reg           <= 1'b0;
        end else begin
            pkt_in_avail_reg <= 1'b0;
            txn_done_reg     <= 1'b0;
            txn_success_reg  <= 1'b0;

            if (is_send_state) begin
                if (bus.encoder_ready) begin
                    pkt_in_reg       <= send_pkt;
                    pkt_in_avail_reg <= 1'b1;
                    seen_low_reg     <= 1'b0;
                    state_reg        <= state_reg + 4'd1;
                end
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (bus.txn_start) begin
                            is_in_reg <= bus.txn_is_in;
                            addr_reg  <= bus.txn_addr;
                            endp_reg  <= bus.txn_endp;
                            wdata_reg <= bus.txn_wdata;
                            retry_reg <= '0;
                            state_reg <= S_TOK_SEND;
                        end
                    end
                    S_TOK_WAIT, S_DAT_WAIT, S_ACK_WAIT, S_NAK_WAIT: begin
                        if (!bus.encoder_ready) begin
                            seen_low_reg <= 1'b1;
                        end else if (send_done) begin
                            seen_low_reg <= 1'b0;
                            if (state_reg == S_TOK_WAIT && !is_in_reg) begin
                                state_reg <= S_DAT_SEND;
                            end else if (state_reg == S_TOK_WAIT || state_reg == S_DAT_WAIT) begin
                                state_reg <= S_RX_WAIT;
                                timer_reg <= '0;
                                re_reg    <= bus.decoder_ready;
                            end else if (state_reg == S_ACK_WAIT) begin
                                state_reg       <= S_DONE;
                                txn_done_reg    <= 1'b1;
                                txn_success_reg <= 1'b1;
                            end else begin
                                state_reg <= S_RETRY;
                            end
                        end
                    end
                    S_RX_WAIT: begin
                        re_reg    <= re_reg | bus.decoder_ready;
                        timer_reg <= timer_inc;
                        // An arriving packet takes priority over an expiring timer.
                        if (bus.pkt_out_avail) begin
                            re_reg <= 1'b0;
                            if (is_in_reg) begin
                                if (!bus.data_good) begin
                                    state_reg <= S_NAK_SEND;
                                end else if (rx_pid == PID_DATA0) begin
                                    txn_rdata_reg <= bus.pkt_out[90:27];
                                    state_reg     <= S_ACK_SEND;
                                end else begin
                                    state_reg <= S_RETRY;
                                end
                            end else if (bus.data_good && rx_pid == PID_ACK) begin
                                state_reg       <= S_DONE;
                                txn_done_reg    <= 1'b1;
                                txn_success_reg <= 1'b1;
                            end else begin
                                state_reg <= S_RETRY;
                            end
                        end else if (timer_inc == TIMEOUT_CNT) begin
                            re_reg    <= 1'b0;
                            state_reg <= S_RETRY;
                        end
                    end
                    S_RETRY: begin
                        retry_reg <= retry_inc;
                        if (retry_inc == RETRY_LIMIT) begin
                            state_reg       <= S_DONE;
                            txn_done_reg    <= 1'b1;
                            txn_success_reg <= 1'b0;
                        end else begin
                            state_reg <= S_TOK_SEND;
                        end
                    end
                    S_DONE: begin
                        state_reg <= S_IDLE;
                    end
                    default: begin
                        state_reg <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.pkt_in       = pkt_in_reg;
    assign bus.pkt_in_avail = pkt_in_avail_reg;
    assign bus.txn_done     = txn_done_reg;
    assign bus.txn_success  = txn_success_reg;
    assign bus.txn_rdata    = txn_rdata_reg;
    assign bus.re           = re_reg;

endmodule

// File: tb/tb_usb_protocol_fsm.sv
// Scoreboard bench for usb_protocol_fsm: directed transactions, a simple
// encoder/device model, and a monitor checking every packet and completion.
module tb_usb_protocol_fsm;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    usb_protocol_fsm_if bus();

    usb_protocol_fsm dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    typedef struct {
        logic        success;
        logic [63:0] rdata;
    } done_t;

    int errors = 0;
    int checks = 0;
    int re_cnt = 0;
    logic [98:0] exp_pkt_q[$];
    done_t       exp_done_q[$];

    task automatic check(input string name, input logic [98:0] got, input logic [98:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    function automatic logic [98:0] tok(input logic [7:0] pid, input logic [6:0] a, input logic [3:0] e);
        return {pid, a, e, 80'd0};
    endfunction

    function automatic logic [98:0] dat(input logic [63:0] payload);
        return {8'hC3, payload, 27'd0};
    endfunction

    function automatic logic [98:0] hs(input logic [7:0] pid);
        return {pid, 91'd0};
    endfunction

    task automatic push_done(input logic success, input logic [63:0] rdata);
        done_t d;
        d.success = success;
        d.rdata   = rdata;
        exp_done_q.push_back(d);
    endtask

    // Monitor: compares every DUT output event against the scoreboard queues.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.re) re_cnt++;
            if (bus.pkt_in_avail) begin
                if (exp_pkt_q.size() == 0) begin
                    fail_now("pkt_in_unexpected");
                end else begin
                    check("pkt_in", bus.pkt_in, exp_pkt_q.pop_front());
                end
            end
            if (bus.txn_done) begin
                $display("txn done success=%0d rdata=%h", bus.txn_success, bus.txn_rdata);
                if (exp_done_q.size() == 0) begin
                    fail_now("txn_done_unexpected");
                end else begin
                    done_t d;
                    d = exp_done_q.pop_front();
                    check("txn_success", 99'(bus.txn_success), 99'(d.success));
                    check("txn_rdata", 99'(bus.txn_rdata), 99'(d.rdata));
                end
            end
        end
    end

    // Encoder model: busy for three cycles after each send strobe.
    initial begin
        bus.encoder_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.pkt_in_avail) begin
                bus.encoder_ready = 1'b0;
                repeat (3) @(negedge clk);
                bus.encoder_ready = 1'b1;
            end
        end
    end

    task automatic start_txn(input logic is_in, input logic [6:0] a, input logic [3:0] e, input logic [63:0] wd);
        @(negedge clk);
        bus.txn_is_in = is_in;
        bus.txn_addr  = a;
        bus.txn_endp  = e;
        bus.txn_wdata = wd;
        bus.txn_start = 1'b1;
        @(negedge clk);
        bus.txn_start = 1'b0;
    endtask

    task automatic wait_re();
        int n = 0;
        while (!bus.re && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!bus.re) fail_now("re_rise");
    endtask

    task automatic send_resp(input logic [7:0] pid, input logic [63:0] payload, input logic good);
        wait_re();
        repeat (2) @(negedge clk);
        bus.pkt_out       = {pid, payload, 27'd0};
        bus.data_good     = good;
        bus.pkt_out_avail = 1'b1;
        @(negedge clk);
        bus.pkt_out_avail = 1'b0;
        bus.data_good     = 1'b0;
        bus.pkt_out       = '0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!bus.txn_done && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!bus.txn_done) fail_now("txn_done_wait");
        @(negedge clk);
        check("pkt_q_left", 99'(exp_pkt_q.size()), 99'd0);
        check("done_q_left", 99'(exp_done_q.size()), 99'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_pkt_in_avail"}, 99'(bus.pkt_in_avail), 99'd0);
        check({tag, "_re"}, 99'(bus.re), 99'd0);
        check({tag, "_txn_done"}, 99'(bus.txn_done), 99'd0);
        check({tag, "_txn_success"}, 99'(bus.txn_success), 99'd0);
        check({tag, "_pkt_in"}, bus.pkt_in, 99'd0);
        check({tag, "_txn_rdata"}, 99'(bus.txn_rdata), 99'd0);
    endtask

    initial begin
        int n;
        bus.txn_start     = 1'b0;
        bus.txn_is_in     = 1'b0;
        bus.txn_addr      = '0;
        bus.txn_endp      = '0;
        bus.txn_wdata     = '0;
        bus.pkt_out       = '0;
        bus.pkt_out_avail = 1'b0;
        bus.data_good     = 1'b0;
        bus.decoder_ready = 1'b1;

        repeat (3) @(negedge clk);
        check_outputs_zero("rst");
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("idle");

        // 1: OUT with immediate ACK
        exp_pkt_q.push_back(tok(8'hE1, 7'h05, 4'h4));
        exp_pkt_q.push_back(dat(64'hDEADBEEF_01234567));
        push_done(1'b1, 64'h0);
        start_txn(1'b0, 7'h05, 4'h4, 64'hDEADBEEF_01234567);
        send_resp(8'hD2, 64'h0, 1'b1);
        wait_done(100);

        // 2: OUT, NAK twice then ACK
        for (int i = 0; i < 3; i++) begin
            exp_pkt_q.push_back(tok(8'hE1, 7'h12, 4'h1));
            exp_pkt_q.push_back(dat(64'h00000000_A5A5A5A5));
        end
        push_done(1'b1, 64'h0);
        start_txn(1'b0, 7'h12, 4'h1, 64'h00000000_A5A5A5A5);
        send_resp(8'h5A, 64'h0, 1'b1);
        send_resp(8'h5A, 64'h0, 1'b1);
        send_resp(8'hD2, 64'h0, 1'b1);
        wait_done(300);

        // 3: IN, good DATA0
        exp_pkt_q.push_back(tok(8'h69, 7'h33, 4'h2));
        exp_pkt_q.push_back(hs(8'hD2));
        push_done(1'b1, 64'hCAFEF00D_12345678);
        start_txn(1'b1, 7'h33, 4'h2, 64'h0);
        send_resp(8'hC3, 64'hCAFEF00D_12345678, 1'b1);
        wait_done(100);

        // 4: IN, bad CRC first (NAK + retry), then good DATA0
        exp_pkt_q.push_back(tok(8'h69, 7'h7F, 4'hF));
        exp_pkt_q.push_back(hs(8'h5A));
        exp_pkt_q.push_back(tok(8'h69, 7'h7F, 4'hF));
        exp_pkt_q.push_back(hs(8'hD2));
        push_done(1'b1, 64'h0BADC0DE_55AA55AA);
        start_txn(1'b1, 7'h7F, 4'hF, 64'h0);
        send_resp(8'hC3, 64'h11111111_22222222, 1'b0);
        send_resp(8'hC3, 64'h0BADC0DE_55AA55AA, 1'b1);
        wait_done(200);

        // 5: IN, device silent: 8 attempts of 255 receive cycles, rdata held
        for (int i = 0; i < 8; i++) exp_pkt_q.push_back(tok(8'h69, 7'h01, 4'h3));
        push_done(1'b0, 64'h0BADC0DE_55AA55AA);
        re_cnt = 0;
        start_txn(1'b1, 7'h01, 4'h3, 64'h0);
        wait_done(3000);
        check("re_high_cycles", 99'(re_cnt), 99'd2040);

        // 6: reset asserted during DAT_WAIT, then a fresh OUT transaction
        exp_pkt_q.push_back(tok(8'hE1, 7'h05, 4'h4));
        exp_pkt_q.push_back(dat(64'h01020304_05060708));
        start_txn(1'b0, 7'h05, 4'h4, 64'h01020304_05060708);
        n = 0;
        while (!(bus.pkt_in_avail && bus.pkt_in[98:91] == 8'hC3) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.pkt_in_avail) fail_now("data_send_wait");
        @(negedge clk);
        #1 rst_b = 1'b0;
        #1 check_outputs_zero("abort");
        repeat (3) @(negedge clk);
        check_outputs_zero("abort_hold");
        rst_b = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_pkt_q", 99'(exp_pkt_q.size()), 99'd0);
        exp_pkt_q.push_back(tok(8'hE1, 7'h05, 4'h4));
        exp_pkt_q.push_back(dat(64'h01020304_05060708));
        push_done(1'b1, 64'h0);
        start_txn(1'b0, 7'h05, 4'h4, 64'h01020304_05060708);
        send_resp(8'hD2, 64'h0, 1'b1);
        wait_done(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
